// File: rtl/fifo_pkg.sv
// fifo_pkg: widths and Gray-code helpers shared by the async FIFO
// read-side and write-side controllers.
package fifo_pkg;

  localparam int FIFO_PTR_WIDTH  = 4;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_PTR_MAX    = 16;

  typedef logic [FIFO_PTR_MAX-1:0] ptr_wide_t;

  // Helpers work at the widest supported pointer; callers zero-extend.
  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: two-flop synchronizer for a Gray pointer crossing into
// the clk domain; synchronous active-low reset.
module gray_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd.sv
// fifo_rd: async FIFO read-side controller (pointer, empty, Gray export).
// Define FIFO_RD_LEVEL_EN to add the r_level occupancy output.
module fifo_rd
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                 r_clk,
  input  logic                 r_rstn,
  input  logic                 r_inc,
  input  logic [PTR_WIDTH-1:0] gray_wr_ptr,
  output logic                 r_empty,
  output logic [PTR_WIDTH-2:0] r_addr,
`ifdef FIFO_RD_LEVEL_EN
  output logic [PTR_WIDTH-1:0] r_level,
`endif
  output logic [PTR_WIDTH-1:0] gray_rd_ptr
);

  if (PTR_WIDTH < 2 || PTR_WIDTH >= FIFO_PTR_MAX
      || DATA_WIDTH < 1) begin : g_bad_cfg
    $error("fifo_rd: unsupported PTR_WIDTH/DATA_WIDTH");
  end

  logic [PTR_WIDTH-1:0] r_ptr;
  logic [PTR_WIDTH-1:0] r_ptr_nxt;
  logic [PTR_WIDTH-1:0] sync_wr_ptr;
  logic                 pop;
  ptr_wide_t            gray_nxt;
  logic                 unused_gray_hi;

  gray_sync #(
    .W (PTR_WIDTH)
  ) u_wr_sync (
    .clk  (r_clk),
    .rstn (r_rstn),
    .d    (gray_wr_ptr),
    .q    (sync_wr_ptr)
  );

  assign pop       = r_inc & ~r_empty;
  assign r_ptr_nxt = r_ptr + PTR_WIDTH'(pop);
  assign gray_nxt  = bin2gray(ptr_wide_t'(r_ptr_nxt));

  assign unused_gray_hi = ^gray_nxt[FIFO_PTR_MAX-1:PTR_WIDTH];

  // Gray copy is loaded from the same next value so it never glitches.
  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      r_ptr       <= '0;
      gray_rd_ptr <= '0;
    end else begin
      r_ptr       <= r_ptr_nxt;
      gray_rd_ptr <= gray_nxt[PTR_WIDTH-1:0];
    end
  end

  assign r_addr  = r_ptr[PTR_WIDTH-2:0];
  assign r_empty = (gray_rd_ptr == sync_wr_ptr);

`ifdef FIFO_RD_LEVEL_EN
  ptr_wide_t wr_bin;
  logic      unused_bin_hi;

  assign wr_bin        = gray2bin(ptr_wide_t'(sync_wr_ptr));
  assign unused_bin_hi = ^wr_bin[FIFO_PTR_MAX-1:PTR_WIDTH];
  assign r_level       = wr_bin[PTR_WIDTH-1:0] - r_ptr;
`endif

endmodule

// File: tb/tb_fifo_rd.sv
// tb_fifo_rd: directed and randomized checks of fifo_rd against
// a count-based reference model.
module tb_fifo_rd;

  logic       r_clk = 1'b0;
  logic       r_rstn;
  logic       r_inc;
  logic [3:0] gray_wr_ptr;
  logic       r_empty;
  logic [2:0] r_addr;
  logic [3:0] gray_rd_ptr;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] r_level;
`endif

  int n_chk = 0;
  int n_err = 0;
  int wp    = 0;
  bit mon_en = 1'b0;

  int m_rp = 0;
  int m_d0 = 0;
  int m_d1 = 0;

  always #5 r_clk = ~r_clk;

  fifo_rd u_dut (
    .r_clk       (r_clk),
    .r_rstn      (r_rstn),
    .r_inc       (r_inc),
    .gray_wr_ptr (gray_wr_ptr),
    .r_empty     (r_empty),
    .r_addr      (r_addr),
`ifdef FIFO_RD_LEVEL_EN
    .r_level     (r_level),
`endif
    .gray_rd_ptr (gray_rd_ptr)
  );

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: read pointer as a count mod 16, write pointer seen
  // two samples late, empty when the two counts agree.
  always @(posedge r_clk) begin
    bit pop;
    pop = (r_inc === 1'b1) && (m_d1 != m_rp);
    if (r_rstn !== 1'b1) begin
      m_rp = 0;
      m_d0 = 0;
      m_d1 = 0;
    end else begin
      if (pop) m_rp = (m_rp + 1) % 16;
      m_d1 = m_d0;
      m_d0 = g2b(gray_wr_ptr);
    end
    #1;
    if (mon_en) begin
      chk("m_empty", 32'(r_empty), 32'(m_d1 == m_rp));
      chk("m_addr", 32'(r_addr), 32'(m_rp % 8));
      chk("m_gray", 32'(gray_rd_ptr), 32'(m_rp ^ (m_rp >> 1)));
`ifdef FIFO_RD_LEVEL_EN
      chk("m_level", 32'(r_level), 32'((m_d1 - m_rp + 16) % 16));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic setw(input int b);
    wp = b % 16;
    gray_wr_ptr = 4'(wp ^ (wp >> 1));
  endtask

  task automatic do_reset(input int n, input int w);
    r_rstn = 1'b0;
    r_inc  = 1'b0;
    setw(w);
    cyc(n);
    r_rstn = 1'b1;
  endtask

  logic [3:0] drain_gray [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};

  initial begin
    int bias;
    r_rstn = 1'b0;
    r_inc  = 1'b0;
    setw(4);
    cyc(2);
    mon_en = 1'b1;
    chk("rst_empty", 32'(r_empty), 32'd1);
    chk("rst_addr", 32'(r_addr), 32'd0);
    chk("rst_gray", 32'(gray_rd_ptr), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("rst_level", 32'(r_level), 32'd0);
`endif
    r_rstn = 1'b1;
    cyc(1);
    chk("rel_empty_e1", 32'(r_empty), 32'd1);
    cyc(1);
    chk("rel_empty_e2", 32'(r_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("rel_level", 32'(r_level), 32'd4);
`endif

    do_reset(1, 0);
    r_inc = 1'b1;
    cyc(5);
    r_inc = 1'b0;
    chk("unf_addr", 32'(r_addr), 32'd0);
    chk("unf_gray", 32'(gray_rd_ptr), 32'd0);
    chk("unf_empty", 32'(r_empty), 32'd1);

    setw(1);
    cyc(1);
    chk("wr1_empty_e1", 32'(r_empty), 32'd1);
    cyc(1);
    chk("wr1_empty_e2", 32'(r_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("wr1_level", 32'(r_level), 32'd1);
`endif
    r_inc = 1'b1;
    cyc(1);
    r_inc = 1'b0;
    chk("pop1_empty", 32'(r_empty), 32'd1);
    chk("pop1_addr", 32'(r_addr), 32'd1);
    chk("pop1_gray", 32'(gray_rd_ptr), 32'd1);

    do_reset(1, 0);
    setw(8);
    cyc(3);
    chk("full_empty", 32'(r_empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    chk("full_level", 32'(r_level), 32'd8);
`endif
    for (int i = 0; i < 8; i++) begin
      r_inc = 1'b1;
      cyc(1);
      chk("drain_gray", 32'(gray_rd_ptr), 32'(drain_gray[i]));
      chk("drain_addr", 32'(r_addr), 32'((i + 1) % 8));
    end
    r_inc = 1'b0;
    chk("drain_empty", 32'(r_empty), 32'd1);

    setw(15);
    cyc(3);
    r_inc = 1'b1;
    cyc(7);
    r_inc = 1'b0;
    chk("pre_wrap_gray", 32'(gray_rd_ptr), 32'd8);
    chk("pre_wrap_empty", 32'(r_empty), 32'd1);
    setw(16);
    cyc(3);
    chk("wrap_avail", 32'(r_empty), 32'd0);
    r_inc = 1'b1;
    cyc(1);
    r_inc = 1'b0;
    chk("wrap_addr", 32'(r_addr), 32'd0);
    chk("wrap_gray", 32'(gray_rd_ptr), 32'd0);
    chk("wrap_empty", 32'(r_empty), 32'd1);

    do_reset(1, 0);
    setw(8);
    cyc(3);
    r_inc = 1'b1;
    cyc(5);
    chk("mid_gray", 32'(gray_rd_ptr), 32'd7);
    r_rstn = 1'b0;
    setw(0);
    cyc(1);
    chk("mid_addr", 32'(r_addr), 32'd0);
    chk("mid_gray_rst", 32'(gray_rd_ptr), 32'd0);
    chk("mid_empty", 32'(r_empty), 32'd1);
    r_rstn = 1'b1;
    r_inc  = 1'b0;

    bias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) bias = int'($urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0) begin
        r_rstn = 1'b0;
        setw(0);
      end else begin
        r_rstn = 1'b1;
        if ((wp - m_rp + 16) % 16 < 8 && $urandom_range(0, 2) != 0)
          setw(wp + 1);
      end
      r_inc = (int'($urandom_range(0, 3)) < bias);
      cyc(1);
    end

    r_inc = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
